// File: rtl/present_round_step_pkg.sv
// Shared widths, S-box table and layer helpers for the PRESENT-80 round step.
package present_round_step_pkg;

  localparam int unsigned STATE_W = 64;
  localparam int unsigned KEY_W   = 80;
  localparam int unsigned CTR_W   = 5;

  // PRESENT 4-bit S-box, indexed by input nibble
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[x];
  endfunction

  // Bit permutation: bit i moves to (16*i) mod 63, bit 63 is fixed
  function automatic logic [STATE_W-1:0] player(input logic [STATE_W-1:0] d);
    logic [STATE_W-1:0] p;
    logic [5:0]         src;
    logic [5:0]         dst;
    p = '0;
    for (int unsigned i = 0; i < 63; i++) begin
      src    = 6'(i);
      dst    = 6'((16 * i) % 63);
      p[dst] = d[src];
    end
    p[63] = d[63];
    return p;
  endfunction

endpackage

// File: rtl/present_round_step_sbox4.sv
// Combinational 4-bit PRESENT S-box.
module present_sbox4
  import present_round_step_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = sbox(i_nib);

endmodule

// File: rtl/present_round_step.sv
// One PRESENT-80 round per accepted input: key addition, sBoxLayer, pLayer,
// and the matching key-schedule update, registered with 1-cycle latency.
module present_round_step
  import present_round_step_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [STATE_W-1:0] state_in,
  input  logic [KEY_W-1:0]   key_in,
  input  logic [CTR_W-1:0]   round_ctr,
  output logic [STATE_W-1:0] ka_out,
  output logic               out_valid,
  output logic [STATE_W-1:0] state_out,
  output logic [KEY_W-1:0]   key_out
);

  logic [STATE_W-1:0] w_ka;
  logic [STATE_W-1:0] w_sb;
  logic [STATE_W-1:0] w_perm;
  logic [KEY_W-1:0]   w_rot;
  logic [3:0]         w_key_sb;
  logic [KEY_W-1:0]   w_key_next;

  logic               r_valid;
  logic [STATE_W-1:0] r_state;
  logic [KEY_W-1:0]   r_key;

  // Key addition; also exported directly for final whitening
  assign w_ka   = state_in ^ key_in[KEY_W-1:KEY_W-STATE_W];
  assign ka_out = w_ka;

  // sBoxLayer: one S-box per state nibble
  for (genvar g = 0; g < 16; g++) begin : g_sbox
    present_sbox4 u_sbox (
      .i_nib (w_ka[4*g +: 4]),
      .o_nib (w_sb[4*g +: 4])
    );
  end

  assign w_perm = player(w_sb);

  // Key schedule: rotate left 61, S-box the top nibble, fold in the round counter
  assign w_rot = {key_in[18:0], key_in[KEY_W-1:19]};

  present_sbox4 u_key_sbox (
    .i_nib (w_rot[79:76]),
    .o_nib (w_key_sb)
  );

  assign w_key_next = {w_key_sb, w_rot[75:20], w_rot[19:15] ^ round_ctr, w_rot[14:0]};

  // Output registers: reset clears, in_valid loads, otherwise hold the result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_state <= '0;
      r_key   <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_state <= w_perm;
        r_key   <= w_key_next;
      end
    end
  end

  assign out_valid = r_valid;
  assign state_out = r_state;
  assign key_out   = r_key;

endmodule

// File: tb/tb_present_round_step.sv
// Scoreboard bench for present_round_step: stimulus pushes expected results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_present_round_step;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] state_in;
  logic [79:0] key_in;
  logic [4:0]  round_ctr;
  logic [63:0] ka_out;
  logic        out_valid;
  logic [63:0] state_out;
  logic [79:0] key_out;

  typedef struct {
    logic [63:0] s;
    logic [79:0] k;
  } exp_t;

  exp_t        q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [63:0] ms;
  logic [79:0] mk;

  present_round_step dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .state_in  (state_in),
    .key_in    (key_in),
    .round_ctr (round_ctr),
    .ka_out    (ka_out),
    .out_valid (out_valid),
    .state_out (state_out),
    .key_out   (key_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model, written independently of the RTL
  function automatic logic [3:0] m_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] m_state(input logic [63:0] s, input logic [79:0] k);
    logic [63:0] t;
    logic [63:0] u;
    logic [63:0] p;
    t = s ^ k[79:16];
    for (int n = 0; n < 16; n++) u[4*n +: 4] = m_sbox(t[4*n +: 4]);
    p = '0;
    // nibble n, bit b lands at 16*b + n
    for (int n = 0; n < 16; n++)
      for (int b = 0; b < 4; b++)
        p[16*b + n] = u[4*n + b];
    return p;
  endfunction

  function automatic logic [79:0] m_key(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = m_sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  // Monitor: every presented output must match the oldest pending expectation
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 80'(out_valid), 80'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("state_out", 80'(state_out), 80'(e.s));
        chk("key_out", key_out, e.k);
      end
    end
  end

  task automatic drive_model(input logic [63:0] s, input logic [79:0] k, input logic [4:0] rc);
    exp_t e;
    @(negedge clk);
    state_in  = s;
    key_in    = k;
    round_ctr = rc;
    in_valid  = 1'b1;
    e.s = m_state(s, k);
    e.k = m_key(k, rc);
    q.push_back(e);
  endtask

  task automatic run_chain(input string name, input logic [63:0] pt,
                           input logic [79:0] key, input logic [63:0] ct);
    ms = pt;
    mk = key;
    for (int r = 1; r <= 31; r++) begin
      drive_model(ms, mk, 5'(r));
      ms = m_state(ms, mk);
      mk = m_key(mk, 5'(r));
    end
    @(negedge clk);
    in_valid = 1'b0;
    state_in = ms;
    key_in   = mk;
    #1;
    chk(name, 80'(ka_out), 80'(ct));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst       = 1'b1;
    in_valid  = 1'b0;
    state_in  = '0;
    key_in    = '0;
    round_ctr = '0;
    repeat (2) @(negedge clk);

    chk("reset_out_valid", 80'(out_valid), 80'd0);
    chk("reset_state_out", 80'(state_out), 80'd0);
    chk("reset_key_out", key_out, 80'd0);

    // ka_out is combinational even while reset is held
    state_in = 64'h0123456789ABCDEF;
    key_in   = 80'hFFFF0000FFFF0000_1234;
    #1;
    chk("ka_out_in_reset", 80'(ka_out), 80'(64'hFEDC45677654CDEF));

    // First round from zero state/key, hand-computed
    @(negedge clk);
    rst       = 1'b0;
    state_in  = '0;
    key_in    = '0;
    round_ctr = 5'd1;
    in_valid  = 1'b1;
    e.s = 64'hFFFFFFFF00000000;
    e.k = 80'hC0000000000000008000;
    q.push_back(e);

    // round_ctr = 0 boundary, then back-to-back chains
    drive_model(64'h0123456789ABCDEF, 80'h0123456789ABCDEF0123, 5'd0);
    run_chain("chain_k0_p0", 64'h0, 80'h0, 64'h5579C1387B228445);
    run_chain("chain_k1_p0", 64'h0, {80{1'b1}}, 64'hE72C46C0F5945049);
    run_chain("chain_k0_p1", {64{1'b1}}, 80'h0, 64'hA112FFC72F68417B);
    run_chain("chain_k1_p1", {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2);

    // Three idle cycles: outputs hold the last round result
    state_in = 64'hDEADBEEFDEADBEEF;
    key_in   = 80'h123456789ABCDEF01234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_out_valid", 80'(out_valid), 80'd0);
      chk("idle_state_hold", 80'(state_out), 80'(ms));
      chk("idle_key_hold", key_out, mk);
    end

    // Reset together with a valid input: the input is discarded
    rst      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_valid_out_valid", 80'(out_valid), 80'd0);
    chk("rst_valid_state_out", 80'(state_out), 80'd0);
    chk("rst_valid_key_out", key_out, 80'd0);
    rst       = 1'b0;
    in_valid  = 1'b1;
    state_in  = '0;
    key_in    = '0;
    round_ctr = 5'd1;
    e.s = 64'hFFFFFFFF00000000;
    e.k = 80'hC0000000000000008000;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;

    for (int c = 0; c < 10 && q.size() != 0; c++) @(negedge clk);
    chk("scoreboard_drain", 80'(q.size()), 80'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
